// File: rtl/prog_clock_divider_pkg.sv
// Shared constants and divisor helpers for the programmable clock divider.
package prog_clock_divider_pkg;

   localparam int unsigned MIN_DIV = 2;
   localparam int unsigned FN_W    = 32;

   // Smallest legal period is two cycles (one high, one low).
   function automatic logic [FN_W-1:0] clamp_div(input logic [FN_W-1:0] d);
      return (d < FN_W'(MIN_DIV)) ? FN_W'(MIN_DIV) : d;
   endfunction

   // ceil(d/2) without risk of overflow in the addition.
   function automatic logic [FN_W-1:0] half_up(input logic [FN_W-1:0] d);
      return (d >> 1) + FN_W'(d[0]);
   endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: period counter, duty compare and shadowed divisor reload.
module clock_divider_channel
   import prog_clock_divider_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEFAULT_DIV = 20
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             en,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_div,
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);

   localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   logic [WIDTH-1:0] div_act;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] div_next;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] half;
   logic [WIDTH-1:0] wr_clamped;
   logic             at_wrap;

   always_comb begin
      div_next   = pending ? shadow : div_act;
      cnt_inc    = cnt + ONE;
      at_wrap    = (cnt == (div_act - ONE));
      half       = WIDTH'(half_up(FN_W'(div_act)));
      wr_clamped = WIDTH'(clamp_div(FN_W'(wr_div)));
   end

   // A shadowed divisor only becomes active at a wrap or while the channel is idle.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         div_act <= DEF_D;
         shadow  <= DEF_D;
         cnt     <= DEF_D - ONE;
         pending <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         if (!en) begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
            div_act <= div_next;
            cnt     <= div_next - ONE;
            pending <= wr_en;
         end else if (at_wrap) begin
            cnt     <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b1;
            div_act <= div_next;
            pending <= wr_en;
         end else begin
            cnt     <= cnt_inc;
            clk_out <= (cnt_inc < half);
            tick    <= 1'b0;
            pending <= pending | wr_en;
         end
         if (wr_en) begin
            shadow <= wr_clamped;
         end
      end
   end

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: config decode and ready mux around per-channel dividers.
module prog_clock_divider
   import prog_clock_divider_pkg::*;
#(
   parameter  int unsigned CHANNELS    = 4,
   parameter  int unsigned WIDTH       = 16,
   parameter  int unsigned DEFAULT_DIV = 20,
   localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic [CHANNELS-1:0] en,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [WIDTH-1:0]    cfg_div,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick
);

   logic [CHANNELS-1:0] pending;
   logic [CHANNELS-1:0] wr_en;

   // Out-of-range channel indices see ready=1 and decode to no write strobe.
   always_comb begin
      cfg_ready = 1'b1;
      wr_en     = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = ~pending[i];
         end
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         wr_en[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      clock_divider_channel #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in  (clk_in),
         .reset   (reset),
         .en      (en[g]),
         .wr_en   (wr_en[g]),
         .wr_div  (cfg_div),
         .pending (pending[g]),
         .clk_out (clk_out[g]),
         .tick    (tick[g])
      );
   end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed and randomized checks of prog_clock_divider against a phase-based reference model.
module tb_prog_clock_divider;

   localparam int unsigned CH  = 5;
   localparam int unsigned W   = 16;
   localparam int unsigned DEF = 20;
   localparam int unsigned CW  = 3;

   logic          clk_in = 1'b0;
   logic          reset;
   logic [CH-1:0] en;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_ch;
   logic [W-1:0]  cfg_div;
   logic [CH-1:0] clk_out;
   logic [CH-1:0] tick;

   always #5 clk_in = ~clk_in;

   // Five channels give a 3-bit index, so indices 5..7 are out of range.
   prog_clock_divider #(
      .CHANNELS    (CH),
      .WIDTH       (W),
      .DEFAULT_DIV (DEF)
   ) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   int checks = 0;
   int errors = 0;

   // Model: position within the current period (-1 = idle), active divisor, queued divisor.
   int            m_d   [CH];
   int            m_pos [CH];
   int            m_sh  [CH];
   bit            m_pend[CH];
   logic [CH-1:0] m_out;
   logic [CH-1:0] m_tick;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready(input logic [CW-1:0] c);
      if (32'(c) >= CH) return 1'b1;
      return !m_pend[c];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_d[c]    = DEF;
         m_pos[c]  = -1;
         m_sh[c]   = DEF;
         m_pend[c] = 1'b0;
      end
      m_out  = '0;
      m_tick = '0;
   endtask

   task automatic model_edge(input bit acc);
      if (reset) begin
         model_reset();
         return;
      end
      for (int c = 0; c < CH; c++) begin
         if (!en[c]) begin
            if (m_pend[c]) begin m_d[c] = m_sh[c]; m_pend[c] = 1'b0; end
            m_pos[c]  = -1;
            m_out[c]  = 1'b0;
            m_tick[c] = 1'b0;
         end else begin
            if (m_pos[c] < 0 || m_pos[c] + 1 >= m_d[c]) begin
               if (m_pend[c]) begin m_d[c] = m_sh[c]; m_pend[c] = 1'b0; end
               m_pos[c] = 0;
            end else begin
               m_pos[c]++;
            end
            m_out[c]  = (m_pos[c] < (m_d[c] + 1) / 2);
            m_tick[c] = (m_pos[c] == 0);
         end
      end
      if (acc && 32'(cfg_ch) < CH) begin
         m_sh[cfg_ch]   = (cfg_div < 2) ? 2 : int'(cfg_div);
         m_pend[cfg_ch] = 1'b1;
      end
   endtask

   task automatic step();
      bit rdy;
      #1;
      rdy = m_ready(cfg_ch);
      chk("cfg_ready", 32'(cfg_ready), 32'(rdy));
      @(posedge clk_in);
      model_edge(cfg_valid && rdy);
      #1;
      chk("clk_out", 32'(clk_out), 32'(m_out));
      chk("tick", 32'(tick), 32'(m_tick));
   endtask

   initial begin
      int          n;
      int          hi;
      int          stalls;
      logic [6:0]  pat;
      logic [3:0]  p_out;
      logic [3:0]  p_tick;

      reset     = 1'b1;
      en        = '1;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;

      // Reset state, then release with all channels enabled.
      step();
      chk("rst_clk_out", 32'(clk_out), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
      reset = 1'b0;
      step();
      chk("first_edge_clk_out", 32'(clk_out), 32'h1F);
      chk("first_edge_tick", 32'(tick), 32'h1F);
      repeat (6) step();

      // ch1 reprogrammed to 5 mid-period.
      cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd5;
      step();
      cfg_valid = 1'b0;
      #1;
      chk("ch1_ready_low", 32'(cfg_ready), 32'h0);
      n = 0;
      do begin step(); n++; end while (!tick[1] && n < 40);
      chk("ch1_old_period_end", 32'(n), 32'd13);
      n = 0; hi = 1;
      do begin step(); n++; hi += int'(clk_out[1] && !tick[1]); end while (!tick[1] && n < 40);
      chk("ch1_period5", 32'(n), 32'd5);
      chk("ch1_high3", 32'(hi), 32'd3);

      // ch2: divisor 0 then 1, second write stalls.
      cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd0;
      step();
      cfg_div = 16'd1;
      stalls = 0;
      while (!cfg_ready && stalls < 40) begin step(); stalls++; end
      chk("ch2_stalled", 32'(stalls > 0 && stalls < 40), 32'h1);
      step();
      cfg_valid = 1'b0;
      repeat (6) step();
      for (int i = 0; i < 4; i++) begin
         step();
         p_out[i]  = clk_out[2];
         p_tick[i] = tick[2];
      end
      chk("ch2_toggle", 32'(p_out == 4'b0101 || p_out == 4'b1010), 32'h1);
      chk("ch2_tick_every2", 32'(p_tick), 32'(p_out));

      // ch0 disabled, reprogrammed to 7, then re-enabled.
      en[0] = 1'b0;
      step();
      cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd7;
      step();
      cfg_valid = 1'b0;
      step();
      #1;
      chk("ch0_ready_after_apply", 32'(cfg_ready), 32'h1);
      en[0] = 1'b1;
      step();
      chk("ch0_first_clk", 32'(clk_out[0]), 32'h1);
      chk("ch0_first_tick", 32'(tick[0]), 32'h1);
      pat[0] = clk_out[0];
      for (int i = 1; i < 7; i++) begin step(); pat[i] = clk_out[0]; end
      chk("ch0_d7_wave", 32'(pat), 32'h0F);
      step();
      chk("ch0_d7_wrap_tick", 32'(tick[0]), 32'h1);

      // Reset in ch3 high phase with a pending write.
      n = 0;
      while (!clk_out[3] && n < 40) begin step(); n++; end
      cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = 16'd3;
      step();
      cfg_valid = 1'b0;
      reset = 1'b1;
      step();
      chk("rst2_clk_out", 32'(clk_out), 32'h0);
      chk("rst2_tick", 32'(tick), 32'h0);
      reset = 1'b0;
      #1;
      chk("ch3_pending_cleared", 32'(cfg_ready), 32'h1);
      step();
      chk("ch3_restart_tick", 32'(tick[3]), 32'h1);
      n = 0;
      do begin step(); n++; end while (!tick[3] && n < 40);
      chk("ch3_period20", 32'(n), 32'd20);

      // Out-of-range channel writes are accepted and dropped.
      for (int i = 5; i < 8; i++) begin
         cfg_valid = 1'b1; cfg_ch = CW'(i); cfg_div = 16'd3;
         #1;
         chk("oor_ready", 32'(cfg_ready), 32'h1);
         step();
      end
      cfg_valid = 1'b0;
      repeat (25) step();

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         reset     = ($urandom_range(0, 699) == 0);
         if ($urandom_range(0, 15) == 0) en ^= CH'(1) << $urandom_range(0, CH - 1);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch    = CW'($urandom_range(0, 7));
         cfg_div   = W'($urandom_range(0, 11));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
